fft8_sched: RTL and testbench

//   Control-only sequencer for the 8-point radix-2 DIT FFT datapath.
//   - Accepts 8 input samples.
//   - Runs 3 butterfly stages over the 8-entry sample buffer.
//   - Streams 8 results out in natural order.
//   - Drives buffer addresses, butterfly issue and the twiddle select.
//   - Raises a scale-request flag for the twiddles that route through the

---
 rtl/fft8_pkg.sv | 26 ++
 rtl/fft8_wb_delay.sv | 58 +++++
 rtl/fft8_sched.sv | 179 +++++++++++++++++
 tb/tb_fft8_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT sequencer: state encoding,
// transform size constants and the load-order bit reversal.
package fft8_pkg;

  localparam int FFT_PTS = 8;
  localparam int ADDR_W  = 3;

  // Last sample / output index; 3-bit counts compare against it explicitly.
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(FFT_PTS - 1);
  // Index of the final butterfly stage (log2(FFT_PTS) - 1).
  localparam logic [1:0]        LAST_STAGE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  // Reverse the three address bits; DIT wants the input in bit-reversed order.
  function automatic logic [ADDR_W-1:0] bitrev3(input logic [ADDR_W-1:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/fft8_wb_delay.sv
// Writeback delay line: carries (valid, upper address, lower address) of each
// butterfly issue through LAT register stages so the buffer write lands when
// the butterfly result emerges from the datapath.
module fft8_wb_delay #(
  parameter int LAT = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       issue_valid,
  input  logic [2:0] issue_addr_a,
  input  logic [2:0] issue_addr_b,
  output logic       wb_valid,
  output logic [2:0] wb_addr_a,
  output logic [2:0] wb_addr_b
);

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tap
      logic       valid_reg;
      logic [2:0] addr_a_reg;
      logic [2:0] addr_b_reg;

      if (gi == 0) begin : g_head
        // First tap captures the issue-cycle addresses.
        always_ff @(posedge clk) begin
          if (srst) begin
            valid_reg  <= 1'b0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
          end else begin
            valid_reg  <= issue_valid;
            addr_a_reg <= issue_addr_a;
            addr_b_reg <= issue_addr_b;
          end
        end
      end else begin : g_body
        // Later taps shift the previous tap along by one cycle.
        always_ff @(posedge clk) begin
          if (srst) begin
            valid_reg  <= 1'b0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
          end else begin
            valid_reg  <= g_tap[gi-1].valid_reg;
            addr_a_reg <= g_tap[gi-1].addr_a_reg;
            addr_b_reg <= g_tap[gi-1].addr_b_reg;
          end
        end
      end
    end
  endgenerate

  assign wb_valid  = g_tap[LAT-1].valid_reg;
  assign wb_addr_a = g_tap[LAT-1].addr_a_reg;
  assign wb_addr_b = g_tap[LAT-1].addr_b_reg;

endmodule

// File: rtl/fft8_sched.sv
// Control sequencer for an 8-point radix-2 DIT FFT: loads samples in
// bit-reversed order, issues 3 stages of 4 butterflies with in-place
// writeback after a fixed latency, then unloads results in natural order.
module fft8_sched
  import fft8_pkg::*;
#(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [2:0] wr_addr_a,
  output logic [2:0] wr_addr_b,
  output logic [2:0] rd_addr_a,
  output logic [2:0] rd_addr_b,
  output logic       bfly_en,
  output logic [1:0] tw_idx,
  output logic       scale_req,
  output logic [1:0] stage
);

  // Butterfly path latency: div_sqrt_2 pipeline plus one multiply register.
  localparam int LAT = N + 1;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg;
  logic [2:0] out_cnt_reg;
  logic [1:0] bcnt_reg;
  logic [1:0] wb_cnt_reg;
  logic [1:0] stage_reg;

  logic       wb_valid;
  logic [2:0] wb_addr_a;
  logic [2:0] wb_addr_b;
  logic       last_wb;

  logic [2:0] span;
  logic [1:0] low_mask;
  logic [1:0] low_bits;
  logic [2:0] iss_addr_a;
  logic [2:0] iss_addr_b;
  logic [1:0] iss_tw;

  // Butterfly leg addresses and twiddle for butterfly bcnt of the current stage.
  always_comb begin
    span       = 3'd1 << stage_reg;
    low_mask   = 2'(span - 3'd1);
    low_bits   = bcnt_reg & low_mask;
    iss_addr_a = (({1'b0, bcnt_reg} >> stage_reg) << (stage_reg + 2'd1)) | {1'b0, low_bits};
    iss_addr_b = iss_addr_a + span;
    iss_tw     = low_bits << (2'd2 - stage_reg);
  end

  // The 4th writeback of a stage closes it; no issue may precede it.
  assign last_wb = wb_valid && (wb_cnt_reg == 2'd3);

  fft8_wb_delay #(
    .LAT(LAT)
  ) u_wb_delay (
    .clk          (clk),
    .srst         (rst),
    .issue_valid  (bfly_en),
    .issue_addr_a (iss_addr_a),
    .issue_addr_b (iss_addr_b),
    .wb_valid     (wb_valid),
    .wb_addr_a    (wb_addr_a),
    .wb_addr_b    (wb_addr_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode plus all strobes and addresses.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    bfly_en    = 1'b0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    tw_idx     = '0;
    wr_en      = wb_valid;
    wr_sel     = wb_valid;
    wr_addr_a  = wb_valid ? wb_addr_a : 3'd0;
    wr_addr_b  = wb_valid ? wb_addr_b : 3'd0;
    unique case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en     = 1'b1;
          wr_sel    = 1'b0;
          wr_addr_a = bitrev3(cnt_reg);
          wr_addr_b = '0;
          if (cnt_reg == LAST_IDX) state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bfly_en   = 1'b1;
        rd_addr_a = iss_addr_a;
        rd_addr_b = iss_addr_b;
        tw_idx    = iss_tw;
        if (bcnt_reg == 2'd3) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_wb) state_next = (stage_reg == LAST_STAGE) ? S_UNLOAD : S_ISSUE;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        rd_addr_a = out_cnt_reg;
        if (out_ready && (out_cnt_reg == LAST_IDX)) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Load, butterfly, writeback, stage and unload counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      out_cnt_reg <= '0;
      bcnt_reg    <= '0;
      wb_cnt_reg  <= '0;
      stage_reg   <= '0;
    end else begin
      if (wb_valid) wb_cnt_reg <= wb_cnt_reg + 2'd1;
      unique case (state_reg)
        S_IDLE: begin
          cnt_reg     <= '0;
          out_cnt_reg <= '0;
          bcnt_reg    <= '0;
          stage_reg   <= '0;
        end
        S_LOAD: begin
          if (in_valid) cnt_reg <= (cnt_reg == LAST_IDX) ? 3'd0 : cnt_reg + 3'd1;
        end
        S_ISSUE: begin
          bcnt_reg <= bcnt_reg + 2'd1;
        end
        S_DRAIN: begin
          if (last_wb && (stage_reg != LAST_STAGE)) stage_reg <= stage_reg + 2'd1;
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (out_cnt_reg == LAST_IDX) begin
              out_cnt_reg <= '0;
              stage_reg   <= '0;
            end else begin
              out_cnt_reg <= out_cnt_reg + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign scale_req = bfly_en & tw_idx[0];
  assign stage     = stage_reg;

endmodule

// File: tb/tb_fft8_sched.sv
// Self-checking bench for fft8_sched: a transaction-level model (load order,
// butterfly pair list, writeback schedule, unload order) checked every cycle
// against an N=3 instance, a latency checker on an N=1 instance, and literal
// tables pinning the first transform.
module tb_fft8_sched;

  localparam int LAT3 = 4;
  localparam int LAT1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic       in_ready, out_valid, busy, done, wr_en, wr_sel, bfly_en, scale_req;
  logic [2:0] wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;
  logic [1:0] tw_idx, stage;

  logic       in_ready_n1, out_valid_n1, busy_n1, done_n1, wr_en_n1, wr_sel_n1, bfly_en_n1, scale_req_n1;
  logic [2:0] wr_addr_a_n1, wr_addr_b_n1, rd_addr_a_n1, rd_addr_b_n1;
  logic [1:0] tw_idx_n1, stage_n1;

  fft8_sched #(.N(3)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .bfly_en(bfly_en), .tw_idx(tw_idx),
    .scale_req(scale_req), .stage(stage)
  );

  fft8_sched #(.N(1)) dut_n1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_n1),
    .out_valid(out_valid_n1), .out_ready(out_ready), .busy(busy_n1), .done(done_n1),
    .wr_en(wr_en_n1), .wr_sel(wr_sel_n1), .wr_addr_a(wr_addr_a_n1), .wr_addr_b(wr_addr_b_n1),
    .rd_addr_a(rd_addr_a_n1), .rd_addr_b(rd_addr_b_n1), .bfly_en(bfly_en_n1), .tw_idx(tw_idx_n1),
    .scale_req(scale_req_n1), .stage(stage_n1)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk_true(input bit ok, input string name, input int act, input int exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_eq(input string name, input int act, input int exp);
    chk_true(act == exp, name, act, exp);
  endtask

  // ---------------- transaction model ----------------
  int cyc = 0;
  int xform = 0;
  int load_q[$];
  int iss_a[$], iss_b[$], iss_tw[$];
  int out_q[$];
  int wb_a[int], wb_b[int];
  int load_n, iss_n, last_load_cyc;
  int stage_start[3];
  bit zero_exp = 1'b0;
  bit prev_done = 1'b0;
  int done_cnt = 0;
  int obs_load[8];
  int obs_a[12], obs_b[12], obs_tw[12];

  // Expected transaction lists for one transform, derived directly from the
  // FFT structure: bit-reversed load, pairs (i, i+span) with bit s of i clear.
  task automatic build_model();
    load_q.delete(); iss_a.delete(); iss_b.delete(); iss_tw.delete(); out_q.delete();
    wb_a.delete(); wb_b.delete();
    for (int i = 0; i < 8; i++) load_q.push_back(((i & 1) << 2) | (i & 2) | ((i >> 2) & 1));
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        if ((i & (1 << s)) == 0) begin
          iss_a.push_back(i);
          iss_b.push_back(i + (1 << s));
          iss_tw.push_back((i % (1 << s)) * (4 >> s));
        end
      end
    end
    for (int i = 0; i < 8; i++) out_q.push_back(i);
    load_n = 0;
    iss_n  = 0;
  endtask

  task automatic clear_model();
    load_q.delete(); iss_a.delete(); iss_b.delete(); iss_tw.delete(); out_q.delete();
    wb_a.delete(); wb_b.delete();
  endtask

  // Compare process for the N=3 instance.
  always @(negedge clk) begin
    int e, ea, eb, et, idx, s;
    cyc++;
    if (zero_exp) begin
      chk_eq("reset_outputs_zero",
             int'({in_ready, out_valid, busy, done, wr_en, wr_sel, bfly_en, scale_req,
                   wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b, tw_idx, stage}), 0);
      zero_exp = 1'b0;
    end
    if (prev_done) begin
      chk_eq("busy_after_done", int'(busy), 0);
      prev_done = 1'b0;
    end
    if (in_ready || out_valid || bfly_en)
      chk_true(!(in_ready && out_valid) && !(bfly_en && (in_ready || out_valid)),
               "invariant_phases", int'({in_ready, out_valid, bfly_en}), 0);
    // load writes
    if ((wr_en && !wr_sel) || (in_valid && in_ready)) begin
      if (load_q.size() == 0) chk_true(1'b0, "load_unexpected", int'(wr_addr_a), -1);
      else begin
        e = load_q.pop_front();
        chk_true(wr_en && !wr_sel && in_valid && in_ready, "load_strobe",
                 int'({wr_en, wr_sel, in_valid, in_ready}), 4'b1011);
        chk_eq("load_addr", int'(wr_addr_a), e);
        if (xform == 1 && load_n < 8) obs_load[load_n] = int'(wr_addr_a);
        load_n++;
        if (load_n == 8) last_load_cyc = cyc;
      end
    end
    // writebacks
    if (wb_a.exists(cyc)) begin
      chk_true(wr_en && wr_sel, "wb_strobe", int'({wr_en, wr_sel}), 3);
      chk_eq("wb_addr_a", int'(wr_addr_a), wb_a[cyc]);
      chk_eq("wb_addr_b", int'(wr_addr_b), wb_b[cyc]);
      wb_a.delete(cyc);
      wb_b.delete(cyc);
    end else if (wr_en && wr_sel) begin
      chk_true(1'b0, "wb_unexpected", int'(wr_addr_a), -1);
    end
    // butterfly issues
    if (bfly_en) begin
      if (iss_a.size() == 0) chk_true(1'b0, "issue_unexpected", int'(rd_addr_a), -1);
      else begin
        idx = iss_n;
        ea = iss_a.pop_front();
        eb = iss_b.pop_front();
        et = iss_tw.pop_front();
        chk_eq("rd_addr_a", int'(rd_addr_a), ea);
        chk_eq("rd_addr_b", int'(rd_addr_b), eb);
        chk_eq("tw_idx", int'(tw_idx), et);
        chk_eq("scale_req", int'(scale_req), et % 2);
        chk_eq("stage", int'(stage), idx / 4);
        if (idx % 4 == 0) begin
          s = idx / 4;
          stage_start[s] = cyc;
          if (s == 0) chk_eq("first_issue_after_load", cyc - last_load_cyc, 1);
          else begin
            chk_eq("stage_spacing", cyc - stage_start[s-1], 4 + LAT3);
            chk_eq("pending_wb_at_issue", wb_a.num(), 0);
          end
        end
        wb_a[cyc + LAT3] = ea;
        wb_b[cyc + LAT3] = eb;
        if (xform == 1 && idx < 12) begin
          obs_a[idx]  = int'(rd_addr_a);
          obs_b[idx]  = int'(rd_addr_b);
          obs_tw[idx] = int'(tw_idx);
        end
        iss_n++;
      end
    end
    // unload
    if (out_valid) begin
      if (out_q.size() == 0) chk_true(1'b0, "out_unexpected", int'(rd_addr_a), -1);
      else begin
        chk_eq("out_addr", int'(rd_addr_a), out_q[0]);
        if (out_ready) begin
          e = out_q.pop_front();
          chk_eq("done_pulse", int'(done), (e == 7) ? 1 : 0);
          if (e == 7) begin
            prev_done = 1'b1;
            done_cnt++;
          end
        end
      end
    end
    if (done && !(out_valid && out_ready)) chk_true(1'b0, "done_spurious", 1, 0);
    // model reset / start
    if (rst) begin
      clear_model();
      zero_exp  = 1'b1;
      prev_done = 1'b0;
    end else if (start && !busy) begin
      build_model();
      xform++;
    end
  end

  // Latency checker for the N=1 instance: each writeback trails its issue by LAT1.
  bit bh[8];
  int ha[8], hb[8];
  int n1_last_stage = -1;
  int n1_stage_first = 0;
  always @(negedge clk) begin
    bit expv;
    expv = bh[LAT1-1];
    if (expv || (wr_en_n1 && wr_sel_n1)) begin
      chk_eq("n1_wb_latency", int'(wr_en_n1 && wr_sel_n1), int'(expv));
      if (expv) begin
        chk_eq("n1_wb_addr_a", int'(wr_addr_a_n1), ha[LAT1-1]);
        chk_eq("n1_wb_addr_b", int'(wr_addr_b_n1), hb[LAT1-1]);
      end
    end
    if (bfly_en_n1 && int'(stage_n1) != n1_last_stage) begin
      if (n1_last_stage >= 0) chk_eq("n1_stage_spacing", cyc - n1_stage_first, 4 + LAT1);
      n1_stage_first = cyc;
      n1_last_stage  = int'(stage_n1);
    end
    for (int k = 7; k > 0; k--) begin
      bh[k] = bh[k-1];
      ha[k] = ha[k-1];
      hb[k] = hb[k-1];
    end
    bh[0] = bfly_en_n1;
    ha[0] = int'(rd_addr_a_n1);
    hb[0] = int'(rd_addr_b_n1);
    if (rst || done_n1) n1_last_stage = -1;
    if (rst) for (int k = 0; k < 8; k++) bh[k] = 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit gapped);
    int n;
    bit hs;
    n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      in_valid = gapped ? (k % 2 == 0) : 1'b1;
      hs = in_valid && in_ready;
      tick();
      if (hs) n++;
    end
    in_valid = 1'b0;
    chk_eq("load_handshakes", n, 8);
  endtask

  task automatic wait_done(input bit always_ready);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 300 && done_cnt == d0; k++) begin
      out_ready = always_ready ? 1'b1 : (k % 3 == 0);
      tick();
    end
    out_ready = 1'b0;
    if (done_cnt == d0) chk_true(1'b0, "done_timeout", 0, 1);
    tick();
    tick();
    chk_eq("model_drained", load_q.size() + iss_a.size() + out_q.size() + wb_a.num(), 0);
  endtask

  initial begin
    int lit_load[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int lit_a[12]   = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b[12]   = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int k;
    for (int i = 0; i < 8; i++) obs_load[i] = -1;
    for (int i = 0; i < 12; i++) begin
      obs_a[i] = -1; obs_b[i] = -1; obs_tw[i] = -1;
    end

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back load, a start pulse while busy, stalled unload.
    run_load(1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0);
    for (int i = 0; i < 8; i++) chk_eq($sformatf("lit_load_%0d", i), obs_load[i], lit_load[i]);
    for (int i = 0; i < 12; i++) begin
      chk_eq($sformatf("lit_rd_a_%0d", i), obs_a[i], lit_a[i]);
      chk_eq($sformatf("lit_rd_b_%0d", i), obs_b[i], lit_b[i]);
      chk_eq($sformatf("lit_tw_%0d", i), obs_tw[i], lit_tw[i]);
    end

    // Gapped input, free-flowing output.
    run_load(1'b1);
    wait_done(1'b1);

    // Abort in the middle of stage 1, then a full rerun.
    run_load(1'b0);
    k = 0;
    while (k < 100 && !(bfly_en && stage == 2'd1)) begin
      tick();
      k++;
    end
    if (k >= 100) chk_true(1'b0, "stage1_timeout", 0, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_load(1'b0);
    wait_done(1'b0);

    // Abort during UNLOAD, then a full rerun.
    run_load(1'b0);
    k = 0;
    while (k < 100 && !out_valid) begin
      tick();
      k++;
    end
    if (k >= 100) chk_true(1'b0, "unload_timeout", 0, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    tick();
    run_load(1'b0);
    wait_done(1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
